// File: rtl/mips_pc_pkg.sv
// rtl/mips_pc_pkg.sv - shared next-PC select encoding and default vectors
package mips_pc_pkg;

    // Source of the next program counter, chosen by the priority encoder
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_RAS,
        SEL_EPC,
        SEL_EXC
    } pc_sel_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/bus bundle between control unit and PC sequencer
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              branch;
    logic              zero;
    logic [15:0]       imm16;
    logic              jump;
    logic [25:0]       target_addr;
    logic              jumpreg;
    logic [ADDR_W-1:0] busA;
    logic              link;
    logic              ret;
    logic              exc;
    logic              eret;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] epc;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;

    // Control unit / register file side
    modport master (
        output stall, branch, zero, imm16, jump, target_addr, jumpreg, busA,
               link, ret, exc, eret,
        input  pc_out, epc, ras_empty, ras_full, ras_ovf
    );

    // Sequencer side
    modport slave (
        input  stall, branch, zero, imm16, jump, target_addr, jumpreg, busA,
               link, ret, exc, eret,
        output pc_out, epc, ras_empty, ras_full, ras_ovf
    );
endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with sticky overflow flag
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]     tp_q, tp_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              do_pop;
    logic              wr_en;
    logic [PW-1:0]     wr_idx;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == DEPTH_C);
    assign ovf    = ovf_q;
    assign top    = mem_q[tp_q];

    // A pop on an empty stack is silently ignored; the caller falls back
    assign do_pop = pop && !empty;

    // Pointer, count and overflow next-state; pop+push rewrites the top in place
    always_comb begin
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        wr_en  = 1'b0;
        wr_idx = tp_q + 1'b1;
        if (push && do_pop) begin
            wr_en  = 1'b1;
            wr_idx = tp_q;
        end else if (push) begin
            wr_en = 1'b1;
            tp_d  = tp_q + 1'b1;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (do_pop) begin
            tp_d  = tp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer/count/flag registers
    always_ff @(posedge clk) begin
        if (!clrn) begin
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Entry storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (clrn && wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with stall, exceptions and RAS
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic           clk,
    input  logic           clrn,
    pc_sequencer_if.slave  sif
);
    localparam logic [ADDR_W-1:0] RST_PC   = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] FOUR     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] WORD_MSK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] seq, btgt, jtgt, rtgt, br_off;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty_w, ras_full_w, ras_ovf_w;
    logic              hold;
    logic              ras_push, ras_pop;
    pc_sel_e           sel;

    // Candidate targets, all modulo 2^ADDR_W
    assign seq    = pc_q + FOUR;
    assign br_off = {{(ADDR_W-18){sif.imm16[15]}}, sif.imm16, 2'b00};
    assign btgt   = seq + br_off;
    assign rtgt   = sif.busA & WORD_MSK;

    generate
        if (ADDR_W > 28) begin : g_jtgt_wide
            assign jtgt = {pc_q[ADDR_W-1:28], sif.target_addr, 2'b00};
        end else begin : g_jtgt_narrow
            assign jtgt = {sif.target_addr, 2'b00};
        end
    endgenerate

    // Priority encoder: exception beats stall, stall freezes everything else
    always_comb begin
        sel  = SEL_SEQ;
        hold = 1'b0;
        if (sif.exc) begin
            sel = SEL_EXC;
        end else if (sif.stall) begin
            hold = 1'b1;
        end else if (sif.eret) begin
            sel = SEL_EPC;
        end else if (sif.jumpreg) begin
            sel = (sif.ret && !ras_empty_w) ? SEL_RAS : SEL_JR;
        end else if (sif.jump) begin
            sel = SEL_J;
        end else if (sif.branch && sif.zero) begin
            sel = SEL_BR;
        end
    end

    // RAS traffic only accompanies an actually selected jump/jumpreg
    assign ras_push = !hold && sif.link &&
                      (sel == SEL_J || sel == SEL_JR || sel == SEL_RAS);
    assign ras_pop  = !hold && sif.ret && (sel == SEL_JR || sel == SEL_RAS);

    // Next PC / EPC from the selected source
    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        if (!hold) begin
            case (sel)
                SEL_EXC: begin
                    pc_d  = EXC_PC;
                    epc_d = pc_q;
                end
                SEL_EPC: pc_d = epc_q;
                SEL_RAS: pc_d = ras_top;
                SEL_JR:  pc_d = rtgt;
                SEL_J:   pc_d = jtgt;
                SEL_BR:  pc_d = btgt;
                default: pc_d = seq;
            endcase
        end
    end

    // PC and EPC registers
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pc_q  <= RST_PC;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .clrn      (clrn),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq),
        .top       (ras_top),
        .empty     (ras_empty_w),
        .full      (ras_full_w),
        .ovf       (ras_ovf_w)
    );

    assign sif.pc_out    = pc_q;
    assign sif.epc       = epc_q;
    assign sif.ras_empty = ras_empty_w;
    assign sif.ras_full  = ras_full_w;
    assign sif.ras_ovf   = ras_ovf_w;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
    localparam int DEPTH = 4;

    logic clk;
    logic clrn;
    int   pass_cnt;
    int   total_cnt;

    pc_sequencer_if #(.ADDR_W(32)) sif ();

    pc_sequencer #(
        .ADDR_W    (32),
        .RAS_DEPTH (DEPTH),
        .RESET_VEC (32'h0),
        .EXC_VEC   (32'h180)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .sif  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: architectural PC, EPC and a bounded stack of return addresses
    logic [31:0] m_pc, m_epc, m_nxt;
    logic [31:0] m_ras [$];
    logic        m_ovf;
    logic        m_valid = 1'b0;

    task automatic m_push(input logic [31:0] a);
        if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
        end
        m_ras.push_back(a);
    endtask

    always @(posedge clk) begin
        if (!clrn) begin
            m_pc = 32'h0; m_epc = 32'h0; m_ras.delete(); m_ovf = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (sif.exc) begin
                m_epc = m_pc; m_pc = 32'h180;
            end else if (sif.stall) begin
                m_pc = m_pc;
            end else if (sif.eret) begin
                m_pc = m_epc;
            end else if (sif.jumpreg) begin
                m_nxt = {sif.busA[31:2], 2'b00};
                if (sif.ret && m_ras.size() > 0) m_nxt = m_ras.pop_back();
                if (sif.link) m_push(m_pc + 32'd4);
                m_pc = m_nxt;
            end else if (sif.jump) begin
                if (sif.link) m_push(m_pc + 32'd4);
                m_pc = {m_pc[31:28], sif.target_addr, 2'b00};
            end else if (sif.branch && sif.zero) begin
                m_pc = m_pc + 32'd4 + 32'(int'($signed(sif.imm16)) * 4);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc_out",    sif.pc_out, m_pc);
            chk("epc",       sif.epc, m_epc);
            chk("ras_empty", {31'd0, sif.ras_empty}, {31'd0, m_ras.size() == 0});
            chk("ras_full",  {31'd0, sif.ras_full},  {31'd0, m_ras.size() == DEPTH});
            chk("ras_ovf",   {31'd0, sif.ras_ovf},   {31'd0, m_ovf});
        end
    end

    task automatic clear();
        sif.stall = 0; sif.branch = 0; sif.zero = 0; sif.imm16 = '0;
        sif.jump = 0; sif.target_addr = '0; sif.jumpreg = 0; sif.busA = '0;
        sif.link = 0; sif.ret = 0; sif.exc = 0; sif.eret = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        clear();
    endtask

    task automatic set_pc(input logic [31:0] a);
        sif.jumpreg = 1; sif.busA = a;
        tick();
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        clear();
        clrn = 0;
        tick();
        chk("rst_pc", sif.pc_out, 32'h0);
        chk("rst_epc", sif.epc, 32'h0);
        chk("rst_empty", {31'd0, sif.ras_empty}, 32'd1);
        clrn = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("idle_pc", sif.pc_out, 32'(i * 4));
        end

        set_pc(32'h100);
        sif.branch = 1; sif.zero = 1; sif.imm16 = 16'hFFFC; tick();
        chk("br_taken", sif.pc_out, 32'h0F4);
        set_pc(32'h100);
        sif.branch = 1; sif.zero = 0; sif.imm16 = 16'hFFFC; tick();
        chk("br_not_taken", sif.pc_out, 32'h104);

        set_pc(32'h40);
        sif.jump = 1; sif.link = 1; sif.target_addr = 26'h100; tick();
        chk("jal_pc", sif.pc_out, 32'h400);
        chk("jal_nonempty", {31'd0, sif.ras_empty}, 32'd0);
        sif.jumpreg = 1; sif.ret = 1; sif.busA = 32'hDEAD; tick();
        chk("ret_pred", sif.pc_out, 32'h44);
        chk("ret_empty", {31'd0, sif.ras_empty}, 32'd1);

        for (int i = 1; i <= 5; i++) begin
            set_pc(32'(i * 16));
            sif.jump = 1; sif.link = 1; sif.target_addr = 26'h200; tick();
        end
        chk("ovf_full", {31'd0, sif.ras_full}, 32'd1);
        chk("ovf_flag", {31'd0, sif.ras_ovf}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            sif.jumpreg = 1; sif.ret = 1; sif.busA = 32'h800; tick();
            chk("ret_chain", sif.pc_out, 32'(32'h54 - i * 16));
        end
        sif.jumpreg = 1; sif.ret = 1; sif.busA = 32'h800; tick();
        chk("ret_underflow", sif.pc_out, 32'h800);

        set_pc(32'h200);
        for (int i = 0; i < 3; i++) begin
            sif.stall = 1; sif.jump = 1; sif.target_addr = 26'h3; tick();
            chk("stall_hold", sif.pc_out, 32'h200);
        end
        sif.stall = 1; sif.exc = 1; tick();
        chk("exc_pc", sif.pc_out, 32'h180);
        chk("exc_epc", sif.epc, 32'h200);
        sif.eret = 1; tick();
        chk("eret_pc", sif.pc_out, 32'h200);

        sif.eret = 1; sif.jumpreg = 1; sif.jump = 1; sif.busA = 32'h999; tick();
        chk("eret_prio", sif.pc_out, 32'h200);
        sif.jumpreg = 1; sif.link = 1; sif.ret = 1; sif.busA = 32'h303; tick();
        chk("jalr_ret_empty", sif.pc_out, 32'h300);
        sif.jumpreg = 1; sif.ret = 1; sif.busA = 32'h0; tick();
        chk("jalr_ret_back", sif.pc_out, 32'h204);

        set_pc(32'hFFFF_FFFF);
        chk("rtgt_align", sif.pc_out, 32'hFFFF_FFFC);
        tick();
        chk("wrap", sif.pc_out, 32'h0);

        sif.jump = 1; sif.link = 1; sif.target_addr = 26'h10; tick();
        clrn = 0; sif.exc = 1; sif.jump = 1; sif.link = 1; sif.target_addr = 26'h20; tick();
        chk("rst2_pc", sif.pc_out, 32'h0);
        chk("rst2_epc", sif.epc, 32'h0);
        chk("rst2_empty", {31'd0, sif.ras_empty}, 32'd1);
        chk("rst2_ovf", {31'd0, sif.ras_ovf}, 32'd0);
        clrn = 1;
        tick();
        chk("post_rst", sif.pc_out, 32'h4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
